// File: rtl/oled_arb_pkg.sv
// ============================================================================
// Module      : oled_arb_pkg
// Description : Shared types and constants for the OLED task arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oled_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANTED   = 2'd1,
    ST_BLANK_OUT = 2'd2
  } arb_state_t;

  localparam logic [1:0] TASK_A = 2'd0;
  localparam logic [1:0] TASK_B = 2'd1;
  localparam logic [1:0] TASK_C = 2'd2;
  localparam logic [1:0] TASK_D = 2'd3;

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] ORANGE = 16'hFD20;
  localparam logic [15:0] BLACK  = 16'h0000;

  // Task A wins over B over C over D.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      return TASK_A;
    else if (v[1]) return TASK_B;
    else if (v[2]) return TASK_C;
    else           return TASK_D;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_debounce.sv
// ============================================================================
// Module      : req_debounce
// Description : Tick-sampled debouncer for one task-select switch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick_1khz,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [7:0] c_DEB_LAST = 8'(DEB_MS - 1);

  logic [7:0] r_cnt;
  logic       r_level;

  // The counter tops out at DEB_MS-1 and is cleared on acceptance, so it never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= 8'd0;
      r_level <= 1'b0;
    end else if (tick_1khz) begin
      if (i_raw != r_level) begin
        if (r_cnt >= c_DEB_LAST) begin
          r_level <= i_raw;
          r_cnt   <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/oled_task_arbiter.sv
// ============================================================================
// Module      : oled_task_arbiter
// Description : Frame-aligned arbiter handing the OLED to one of four tasks.
//               Define OLED_ARB_PREEMPT_EN to let a higher-priority request
//               preempt the current owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_task_arbiter
  import oled_arb_pkg::*;
#(
  parameter int          DEB_MS       = 20,
  parameter int          BLANK_FRAMES = 2,
  parameter logic [15:0] IDLE_COLOR   = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        tick_1khz,
  input  logic        frame_begin,
  input  logic [3:0]  req,
  input  logic [63:0] pix_in,
  output logic [15:0] pixel_data,
  output logic [3:0]  grant,
  output logic        busy
);

  localparam logic [3:0] c_BLANK_LOAD = 4'(BLANK_FRAMES);

  logic [3:0]  w_deb_req;
  logic [1:0]  w_lowest;
  logic [15:0] w_owner_pix;
  logic        w_release;

  arb_state_t  r_state;
  logic [1:0]  r_owner;
  logic [3:0]  r_blank;
  logic [3:0]  r_grant;
  logic        r_busy;
  logic [15:0] r_pix;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      req_debounce #(
        .DEB_MS (DEB_MS)
      ) u_deb (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .tick_1khz (tick_1khz),
        .i_raw     (req[gi]),
        .o_level   (w_deb_req[gi])
      );
    end
  endgenerate

  assign w_lowest    = lowest_set(w_deb_req);
  assign w_owner_pix = pix_in[{r_owner, 4'b0000} +: 16];

`ifdef OLED_ARB_PREEMPT_EN
  logic [3:0] w_lower_mask;
  assign w_lower_mask = onehot4(r_owner) - 4'd1;
  assign w_release    = ~w_deb_req[r_owner] | (|(w_deb_req & w_lower_mask));
`else
  assign w_release    = ~w_deb_req[r_owner];
`endif

  // The pixel register follows the state held before each edge, giving one cycle of latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_owner <= TASK_A;
      r_blank <= 4'd0;
      r_grant <= 4'd0;
      r_busy  <= 1'b0;
      r_pix   <= IDLE_COLOR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pix <= IDLE_COLOR;
          if (frame_begin && (|w_deb_req)) begin
            r_state <= ST_GRANTED;
            r_owner <= w_lowest;
            r_grant <= onehot4(w_lowest);
            r_busy  <= 1'b1;
          end
        end
        ST_GRANTED: begin
          r_pix <= w_owner_pix;
          // A frame_begin coinciding with release is deliberately not counted.
          if (w_release) begin
            r_state <= ST_BLANK_OUT;
            r_grant <= 4'd0;
            r_blank <= c_BLANK_LOAD;
          end
        end
        ST_BLANK_OUT: begin
          r_pix <= BLACK;
          if (r_blank == 4'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (frame_begin) begin
            r_blank <= r_blank - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 4'd0;
          r_busy  <= 1'b0;
          r_pix   <= IDLE_COLOR;
        end
      endcase
    end
  end

  assign pixel_data = r_pix;
  assign grant      = r_grant;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_oled_task_arbiter.sv
// ============================================================================
// Module      : tb_oled_task_arbiter
// Description : Two arbiter configurations driven by shared stimulus and
//               checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_task_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1khz = 1'b0;
  logic        frame_begin = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [63:0] pix_in = 64'd0;

  logic [15:0] pix0, pix1;
  logic [3:0]  grant0, grant1;
  logic        busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  localparam logic [15:0] IC1 = 16'hFD20;

  always #5 clk = ~clk;

  oled_task_arbiter #(.DEB_MS(20), .BLANK_FRAMES(2), .IDLE_COLOR(16'h0000)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .tick_1khz(tick_1khz), .frame_begin(frame_begin),
    .req(req), .pix_in(pix_in), .pixel_data(pix0), .grant(grant0), .busy(busy0)
  );

  oled_task_arbiter #(.DEB_MS(3), .BLANK_FRAMES(1), .IDLE_COLOR(IC1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .tick_1khz(tick_1khz), .frame_begin(frame_begin),
    .req(req), .pix_in(pix_in), .pixel_data(pix1), .grant(grant1), .busy(busy1)
  );

  // Behavioural model: owner/blank are plain integers, -1 meaning "none".
  generate
    for (genvar g = 0; g < 2; g++) begin : g_model
      localparam int          DM = (g == 0) ? 20 : 3;
      localparam int          BF = (g == 0) ? 2 : 1;
      localparam logic [15:0] IC = (g == 0) ? 16'h0000 : IC1;

      int          run [4];
      logic [3:0]  deb;
      int          owner;
      int          blank;
      logic [3:0]  exp_grant;
      logic        exp_busy;
      logic [15:0] exp_pix;

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 4; i++) run[i] = 0;
          deb = 4'd0; owner = -1; blank = -1;
          exp_grant = 4'd0; exp_busy = 1'b0; exp_pix = IC;
        end else begin
          bit rel;
          int low;
          if (owner >= 0)      exp_pix = pix_in[16*owner +: 16];
          else if (blank >= 0) exp_pix = 16'h0000;
          else                 exp_pix = IC;

          if (owner >= 0) begin
            rel = !deb[owner];
`ifdef OLED_ARB_PREEMPT_EN
            for (int i = 0; i < owner; i++) if (deb[i]) rel = 1'b1;
`endif
            if (rel) begin owner = -1; blank = BF; end
          end else if (blank >= 0) begin
            if (blank == 0) blank = -1;
            else if (frame_begin) blank = blank - 1;
          end else if (frame_begin && deb != 4'd0) begin
            low = -1;
            for (int i = 3; i >= 0; i--) if (deb[i]) low = i;
            owner = low;
          end

          if (tick_1khz) begin
            for (int i = 0; i < 4; i++) begin
              if (req[i] != deb[i]) begin
                run[i] = run[i] + 1;
                if (run[i] >= DM) begin deb[i] = req[i]; run[i] = 0; end
              end else begin
                run[i] = 0;
              end
            end
          end

          exp_grant = (owner >= 0) ? 4'(1 << owner) : 4'd0;
          exp_busy  = (owner >= 0) || (blank >= 0);
        end
      end
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("i0 grant",  32'(grant0), 32'(g_model[0].exp_grant));
      chk("i0 busy",   32'(busy0),  32'(g_model[0].exp_busy));
      chk("i0 pixel",  32'(pix0),   32'(g_model[0].exp_pix));
      chk("i0 onehot", 32'($countones(grant0) <= 1), 32'd1);
      chk("i1 grant",  32'(grant1), 32'(g_model[1].exp_grant));
      chk("i1 busy",   32'(busy1),  32'(g_model[1].exp_busy));
      chk("i1 pixel",  32'(pix1),   32'(g_model[1].exp_pix));
      chk("i1 onehot", 32'($countones(grant1) <= 1), 32'd1);
    end
  end

  task automatic drive(input bit t, input bit f);
    @(negedge clk);
    tick_1khz   = t;
    frame_begin = f;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0); end
  endtask

  task automatic frame3();
    drive(1'b0, 1'b1); drive(1'b0, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
  endtask

  logic [3:0] exp_pre;

  initial begin
    pix_in = {16'h001F, 16'h07E0, 16'hF800, 16'hFFFF};
    repeat (3) drive(1'b0, 1'b0);
    cmp_en = 1'b1;
    chk("reset grant0", 32'(grant0), 32'd0);
    chk("reset busy0",  32'(busy0),  32'd0);
    chk("reset pix1",   32'(pix1),   32'(IC1));
    rst_n = 1'b1;

    // Switch bounce shorter than the debounce window never reaches the arbiter.
    for (int k = 0; k < 20; k++) begin
      req = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      run_ticks(5);
    end
    drive(1'b0, 1'b1); drive(1'b0, 1'b0);
    chk("bounce grant0", 32'(grant0), 32'd0);

    // Exactly DEB_MS ticks then a frame start grants task B.
    req = 4'b0010;
    run_ticks(20);
    drive(1'b0, 1'b1); drive(1'b0, 1'b0);
    chk("grantB grant0", 32'(grant0), 32'b0010);
    chk("grantB busy0",  32'(busy0),  32'd1);
    chk("grantB grant1", 32'(grant1), 32'b0010);
    drive(1'b0, 1'b0);
    chk("grantB pix0",   32'(pix0),   32'hF800);

    // Release B: two blank frames, then idle.
    req = 4'b0000;
    run_ticks(20);
    chk("blank grant0", 32'(grant0), 32'd0);
    chk("blank busy0",  32'(busy0),  32'd1);
    drive(1'b0, 1'b0);
    chk("blank pix0",   32'(pix0),   32'h0000);
    frame3();
    chk("blank1 busy0", 32'(busy0),  32'd1);
    frame3();
    chk("idle busy0",   32'(busy0),  32'd0);
    chk("idle pix1",    32'(pix1),   32'(IC1));

    // Owner C, then a request from A.
    req = 4'b0100;
    run_ticks(20);
    drive(1'b0, 1'b1); drive(1'b0, 1'b0);
    chk("grantC grant0", 32'(grant0), 32'b0100);
    req = 4'b0101;
    run_ticks(20);
    frame3(); frame3(); frame3();
`ifdef OLED_ARB_PREEMPT_EN
    exp_pre = 4'b0001;
`else
    exp_pre = 4'b0100;
`endif
    chk("preempt grant0", 32'(grant0), 32'(exp_pre));

    req = 4'b0000;
    run_ticks(20);
    frame3(); frame3(); frame3();
    req = 4'b1111;
    run_ticks(20);
    drive(1'b0, 1'b1); drive(1'b0, 1'b0);
    chk("all grant0", 32'(grant0), 32'b0001);
    chk("all grant1", 32'(grant1), 32'b0001);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async grant0", 32'(grant0), 32'd0);
    chk("async pix0",   32'(pix0),   32'h0000);
    chk("async grant1", 32'(grant1), 32'd0);
    chk("async pix1",   32'(pix1),   32'(IC1));
    chk("async busy1",  32'(busy1),  32'd0);
    drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    rst_n = 1'b1;

    // Release coinciding with frame_begin on the BLANK_FRAMES=1 instance.
    req = 4'b0001;
    run_ticks(20);
    drive(1'b0, 1'b1); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    req = 4'b0000;
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("coinc grant1", 32'(grant1), 32'd0);
    chk("coinc busy1",  32'(busy1),  32'd1);
    repeat (4) drive(1'b0, 1'b0);
    chk("coinc hold busy1", 32'(busy1), 32'd1);
    frame3();
    chk("coinc idle busy1", 32'(busy1), 32'd0);
    chk("coinc idle pix1",  32'(pix1),  32'(IC1));

    // Randomised traffic.
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      rst_n       = 1'b1;
      tick_1khz   = (c % 3 == 0);
      frame_begin = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) req = 4'($urandom);
      pix_in = {$urandom, $urandom};
      if ($urandom_range(0, 2999) == 0) #2 rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
